// File: rtl/hyperram_responder_pkg.sv
// Shared types and constants for the HyperRAM device-side responder.
// Provides package hyperram_pkg (state encoding, CA field positions, register map).
package hyperram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_RDATA,
        ST_WDATA
    } resp_state_e;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_ID0,
        REG_CR0
    } reg_sel_e;

    localparam int CA_RW = 47;
    localparam int CA_AS = 46;
    localparam int CA_BT = 45;

    localparam logic [15:0] CR0_RESET = 16'h8F1F;
    localparam logic [31:0] CR0_ADDR  = 32'h0000_0800;
    localparam logic [31:0] ID0_ADDR  = 32'h0000_0000;

endpackage

// File: rtl/hyperram_responder_if.sv
// Abstract single-edge HyperBus between a host controller (master) and the responder (slave).
interface hyperram_responder_if;

    logic        csn;
    logic        ck_en;
    logic [15:0] dq_in;
    logic        rwds_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        rwds_out;
    logic        rwds_oe;
    logic        busy;

    modport master (
        output csn, ck_en, dq_in, rwds_in,
        input  dq_out, dq_oe, rwds_out, rwds_oe, busy
    );

    modport slave (
        input  csn, ck_en, dq_in, rwds_in,
        output dq_out, dq_oe, rwds_out, rwds_oe, busy
    );

endinterface

// File: rtl/hyperram_resp_mem.sv
// Single-port backing store for the responder: 16-bit words, registered read.
module hyperram_resp_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH_WORDS];

    // rdata only moves on re, so it holds across idle bus cycles
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hyperram_responder.sv
// HyperRAM device-side model: CA decode, fixed latency, burst read/write into internal RAM.
// Optional ID0/CR0 register space is built when HYPERRAM_RESP_REGSPACE_EN is defined.
module hyperram_responder
    import hyperram_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LAT_CYCLES  = 6,
    parameter int          BURST_WORDS = 16,
    parameter logic [15:0] ID0_VALUE   = 16'h0C81
) (
    input  logic                clk,
    input  logic                rst,
    hyperram_responder_if.slave bus
);

    localparam int              AW       = $clog2(DEPTH_WORDS);
    localparam int              LW       = $clog2(LAT_CYCLES + 1);
    localparam logic [AW-1:0]   BMASK    = AW'(BURST_WORDS - 1);
    localparam logic [LW-1:0]   LAT_LAST = LW'(LAT_CYCLES - 1);
    localparam logic [LW-1:0]   LAT_MAX  = LW'(LAT_CYCLES);

    resp_state_e   state_reg, state_next;
    logic [31:0]   ca_reg, ca_next;
    logic [1:0]    ca_cnt_reg, ca_cnt_next;
    logic [LW-1:0] lat_cnt_reg, lat_cnt_next;
    logic          rw_reg, rw_next;
    logic          as_reg, as_next;
    logic          lin_reg, lin_next;
    reg_sel_e      reg_sel_reg, reg_sel_next;
    logic          reg_done_reg, reg_done_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [15:0]   dq_out_reg, dq_out_next;
    logic          dq_oe_reg, dq_oe_next;
    logic          rwds_out_reg, rwds_out_next;
    logic          rwds_oe_reg, rwds_oe_next;

    logic [47:0]   ca_full;
    logic [31:0]   ca_addr;
    logic [AW-1:0] addr_inc;
    logic [15:0]   reg_rdata;
    logic [15:0]   rd_data;
    logic          reg_write_direct;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;

    // Third CA word is still on dq_in when decoding, so combine it with the two captured words
    assign ca_full = {ca_reg, bus.dq_in};
    assign ca_addr = {ca_full[44:16], ca_full[2:0]};

    assign addr_inc = lin_reg ? addr_reg + AW'(1)
                              : (addr_reg & ~BMASK) | ((addr_reg + AW'(1)) & BMASK);

`ifdef HYPERRAM_RESP_REGSPACE_EN
    logic [15:0] cr0_reg, cr0_next;

    assign reg_write_direct = ca_full[CA_AS] & ~ca_full[CA_RW];

    always_comb begin
        case (reg_sel_reg)
            REG_ID0: reg_rdata = ID0_VALUE;
            REG_CR0: reg_rdata = cr0_reg;
            default: reg_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cr0_reg <= CR0_RESET;
        end else begin
            cr0_reg <= cr0_next;
        end
    end
`else
    assign reg_write_direct = 1'b0;
    assign reg_rdata        = 16'h0000;
    wire unused_regspace = ^{reg_sel_reg, reg_done_reg, ID0_VALUE};
`endif

    assign rd_data = as_reg ? reg_rdata : mem_rdata;

    wire unused_ca = ^ca_full[15:3];

    always_comb begin
        state_next    = state_reg;
        ca_next       = ca_reg;
        ca_cnt_next   = ca_cnt_reg;
        lat_cnt_next  = lat_cnt_reg;
        rw_next       = rw_reg;
        as_next       = as_reg;
        lin_next      = lin_reg;
        reg_sel_next  = reg_sel_reg;
        reg_done_next = reg_done_reg;
        addr_next     = addr_reg;
        dq_out_next   = dq_out_reg;
        dq_oe_next    = dq_oe_reg;
        rwds_out_next = rwds_out_reg;
        rwds_oe_next  = rwds_oe_reg;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_addr      = addr_reg;
`ifdef HYPERRAM_RESP_REGSPACE_EN
        cr0_next      = cr0_reg;
`endif

        // csn deassertion wins over any transfer in the same cycle
        if (state_reg != ST_IDLE && bus.csn) begin
            state_next    = ST_IDLE;
            dq_oe_next    = 1'b0;
            rwds_oe_next  = 1'b0;
            rwds_out_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!bus.csn) begin
                        state_next    = ST_CA;
                        ca_cnt_next   = 2'd0;
                        rwds_oe_next  = 1'b1;
                        rwds_out_next = 1'b1;
                    end
                end
                ST_CA: begin
                    if (bus.ck_en) begin
                        ca_next     = {ca_reg[15:0], bus.dq_in};
                        ca_cnt_next = ca_cnt_reg + 2'd1;
                        if (ca_cnt_reg == 2'd2) begin
                            rwds_oe_next  = 1'b0;
                            rwds_out_next = 1'b0;
                            rw_next       = ca_full[CA_RW];
                            as_next       = ca_full[CA_AS];
                            lin_next      = ca_full[CA_BT];
                            addr_next     = ca_addr[AW-1:0];
                            reg_done_next = 1'b0;
                            lat_cnt_next  = '0;
                            if (ca_addr == ID0_ADDR) begin
                                reg_sel_next = REG_ID0;
                            end else if (ca_addr == CR0_ADDR) begin
                                reg_sel_next = REG_CR0;
                            end else begin
                                reg_sel_next = REG_NONE;
                            end
                            state_next = reg_write_direct ? ST_WDATA : ST_LAT;
                        end
                    end
                end
                ST_LAT: begin
                    if (bus.ck_en) begin
                        if (lat_cnt_reg >= LAT_LAST) begin
                            lat_cnt_next = LAT_MAX;
                            state_next   = rw_reg ? ST_RDATA : ST_WDATA;
                            // prefetch word 0 so it is ready for the first RDATA transfer
                            mem_re       = rw_reg;
                        end else begin
                            lat_cnt_next = lat_cnt_reg + LW'(1);
                        end
                    end
                end
                ST_RDATA: begin
                    if (bus.ck_en) begin
                        dq_out_next   = rd_data;
                        dq_oe_next    = 1'b1;
                        rwds_oe_next  = 1'b1;
                        rwds_out_next = 1'b1;
                        if (!as_reg) begin
                            addr_next = addr_inc;
                            mem_re    = 1'b1;
                            mem_addr  = addr_inc;
                        end
                    end else begin
                        rwds_out_next = 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (bus.ck_en) begin
                        addr_next = addr_inc;
`ifdef HYPERRAM_RESP_REGSPACE_EN
                        if (as_reg) begin
                            if (!reg_done_reg) begin
                                reg_done_next = 1'b1;
                                if (reg_sel_reg == REG_CR0 && !bus.rwds_in) begin
                                    cr0_next = bus.dq_in;
                                end
                            end
                        end else begin
                            mem_we = ~bus.rwds_in;
                        end
`else
                        mem_we = ~as_reg & ~bus.rwds_in;
`endif
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            ca_reg       <= '0;
            ca_cnt_reg   <= '0;
            lat_cnt_reg  <= '0;
            rw_reg       <= 1'b0;
            as_reg       <= 1'b0;
            lin_reg      <= 1'b0;
            reg_sel_reg  <= REG_NONE;
            reg_done_reg <= 1'b0;
            addr_reg     <= '0;
            dq_out_reg   <= '0;
            dq_oe_reg    <= 1'b0;
            rwds_out_reg <= 1'b0;
            rwds_oe_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ca_reg       <= ca_next;
            ca_cnt_reg   <= ca_cnt_next;
            lat_cnt_reg  <= lat_cnt_next;
            rw_reg       <= rw_next;
            as_reg       <= as_next;
            lin_reg      <= lin_next;
            reg_sel_reg  <= reg_sel_next;
            reg_done_reg <= reg_done_next;
            addr_reg     <= addr_next;
            dq_out_reg   <= dq_out_next;
            dq_oe_reg    <= dq_oe_next;
            rwds_out_reg <= rwds_out_next;
            rwds_oe_reg  <= rwds_oe_next;
        end
    end

    hyperram_resp_mem #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (bus.dq_in),
        .rdata (mem_rdata)
    );

    assign bus.dq_out   = dq_out_reg;
    assign bus.dq_oe    = dq_oe_reg;
    assign bus.rwds_out = rwds_out_reg;
    assign bus.rwds_oe  = rwds_oe_reg;
    assign bus.busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder: vector table of bus transactions plus corner-case sequences.
module tb_hyperram_responder;

    localparam int LAT = 6;

    typedef struct {
        string       name;
        bit          rd;
        logic [47:0] ca;
        int          n;
        logic [15:0] d [4];
        logic [3:0]  m;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [9];

    always #5 clk = ~clk;

    hyperram_responder_if bus();

    hyperram_responder #(
        .DEPTH_WORDS (1024),
        .LAT_CYCLES  (LAT),
        .BURST_WORDS (16),
        .ID0_VALUE   (16'h0C81)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_ca(input logic [47:0] ca);
        bus.csn   = 1'b0;
        bus.ck_en = 1'b0;
        tick();
        check_bit("latency flag oe", bus.rwds_oe, 1'b1);
        check_bit("latency flag", bus.rwds_out, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.dq_in = ca[47-16*i -: 16];
            bus.ck_en = 1'b1;
            tick();
        end
        check_bit("rwds_oe after CA", bus.rwds_oe, 1'b0);
    endtask

    task automatic end_burst;
        bus.ck_en   = 1'b0;
        bus.rwds_in = 1'b0;
        bus.csn     = 1'b1;
        tick();
    endtask

    task automatic do_read(input string name, input logic [47:0] ca, input int n,
                           input logic [15:0] exp [4]);
        start_ca(ca);
        bus.ck_en = 1'b1;
        // transfer j = LAT+1 is the first data word
        for (int j = 1; j <= LAT + n; j++) begin
            tick();
            if (j <= LAT) begin
                check_bit({name, " strobe during latency"}, bus.rwds_out, 1'b0);
            end else begin
                check({name, " data"}, bus.dq_out, exp[j-LAT-1]);
                check_bit({name, " strobe"}, bus.rwds_out, 1'b1);
            end
        end
        end_burst();
        check_bit({name, " busy after csn"}, bus.busy, 1'b0);
        check_bit({name, " dq_oe after csn"}, bus.dq_oe, 1'b0);
        $display("read  %-24s ca=%h words=%0d", name, ca, n);
    endtask

    task automatic do_write(input string name, input logic [47:0] ca, input int n, input bit zero_lat,
                            input logic [15:0] d [4], input logic [3:0] m);
        start_ca(ca);
        if (!zero_lat) begin
            bus.ck_en = 1'b1;
            repeat (LAT) tick();
        end
        for (int i = 0; i < n; i++) begin
            bus.dq_in   = d[i];
            bus.rwds_in = m[i];
            bus.ck_en   = 1'b1;
            tick();
        end
        check_bit({name, " dq_oe during write"}, bus.dq_oe, 1'b0);
        end_burst();
        $display("write %-24s ca=%h words=%0d mask=%b", name, ca, n, m);
    endtask

    task automatic set_vec(input int i, input string name, input bit rd, input logic [47:0] ca,
                           input int n, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3, input logic [3:0] m);
        vecs[i].name = name;
        vecs[i].rd   = rd;
        vecs[i].ca   = ca;
        vecs[i].n    = n;
        vecs[i].d[0] = d0;
        vecs[i].d[1] = d1;
        vecs[i].d[2] = d2;
        vecs[i].d[3] = d3;
        vecs[i].m    = m;
    endtask

    initial begin
        logic [15:0] w [4];

        // Word address = {ca[44:16], ca[2:0]}: e.g. word 0xE is upper column 1, lower column 6.
        // Memory is preloaded with D000+addr for words 0..15 before the table runs.
        set_vec(0, "mem write linear",  1'b0, 48'h2000_0000_0004, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0000);
        set_vec(1, "mem read linear",   1'b1, 48'hA000_0000_0004, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0000);
        set_vec(2, "wrapped read E",    1'b1, 48'h8000_0001_0006, 4, 16'hD00E, 16'hD00F, 16'hD000, 16'hD001, 4'b0000);
        set_vec(3, "masked write",      1'b0, 48'h2000_0001_0000, 3, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000, 4'b0010);
        set_vec(4, "masked readback",   1'b1, 48'hA000_0001_0000, 3, 16'hAAAA, 16'hD009, 16'hCCCC, 16'h0000, 4'b0000);
        set_vec(5, "wrapped write F",   1'b0, 48'h0000_0001_0007, 2, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b0000);
        set_vec(6, "wrap write check",  1'b1, 48'hA000_0000_0000, 2, 16'h5678, 16'hD001, 16'h0000, 16'h0000, 4'b0000);
        set_vec(7, "linear wrap write", 1'b0, 48'h2000_007F_0007, 2, 16'h5A5A, 16'hA5A5, 16'h0000, 16'h0000, 4'b0000);
        set_vec(8, "linear wrap read",  1'b1, 48'hA000_007F_0007, 2, 16'h5A5A, 16'hA5A5, 16'h0000, 16'h0000, 4'b0000);

        bus.csn     = 1'b1;
        bus.ck_en   = 1'b0;
        bus.dq_in   = 16'h0000;
        bus.rwds_in = 1'b0;
        repeat (3) tick();
        check("reset dq_out", bus.dq_out, 16'h0000);
        check_bit("reset dq_oe", bus.dq_oe, 1'b0);
        check_bit("reset rwds_out", bus.rwds_out, 1'b0);
        check_bit("reset rwds_oe", bus.rwds_oe, 1'b0);
        check_bit("reset busy", bus.busy, 1'b0);
        rst = 1'b1;
        tick();
        check_bit("busy after reset release", bus.busy, 1'b0);

        start_ca(48'h2000_0000_0000);
        bus.ck_en = 1'b1;
        repeat (LAT) tick();
        for (int i = 0; i < 16; i++) begin
            bus.dq_in = 16'hD000 + 16'(i);
            tick();
        end
        end_burst();
        $display("write preload                  ca=200000000000 words=16");

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rd) begin
                do_read(vecs[i].name, vecs[i].ca, vecs[i].n, vecs[i].d);
            end else begin
                do_write(vecs[i].name, vecs[i].ca, vecs[i].n, 1'b0, vecs[i].d, vecs[i].m);
            end
        end

        // Read with an idle gap: strobe drops, data holds
        start_ca(48'hA000_0000_0004);
        bus.ck_en = 1'b1;
        repeat (LAT + 1) tick();
        check("gap read word0", bus.dq_out, 16'h1111);
        bus.ck_en = 1'b0;
        tick();
        check_bit("gap strobe low", bus.rwds_out, 1'b0);
        check("gap data holds", bus.dq_out, 16'h1111);
        check_bit("gap dq_oe stays", bus.dq_oe, 1'b1);
        bus.ck_en = 1'b1;
        tick();
        check("gap read word1", bus.dq_out, 16'h2222);
        check_bit("gap strobe word1", bus.rwds_out, 1'b1);
        end_burst();
        $display("read  gap sequence             ca=a00000000004 words=2");

`ifdef HYPERRAM_RESP_REGSPACE_EN
        w = '{16'h0C81, 16'h0C81, 16'h0000, 16'h0000};
        do_read("ID0 read", 48'hC000_0000_0000, 2, w);
        w = '{16'h8F1F, 16'h0000, 16'h0000, 16'h0000};
        do_read("CR0 reset value", 48'hC000_0100_0000, 1, w);
        w = '{16'h8F17, 16'h1234, 16'h0000, 16'h0000};
        do_write("CR0 write zero latency", 48'h6000_0100_0000, 2, 1'b1, w, 4'b0000);
        w = '{16'h8F17, 16'h8F17, 16'h0000, 16'h0000};
        do_read("CR0 readback", 48'hC000_0100_0000, 2, w);
        w = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        do_write("ID0 write dropped", 48'h6000_0000_0000, 1, 1'b1, w, 4'b0000);
        w = '{16'h0C81, 16'h0000, 16'h0000, 16'h0000};
        do_read("ID0 after write", 48'hC000_0000_0000, 1, w);
        w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        do_read("unmapped register", 48'hC000_0000_0001, 1, w);
`else
        w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        do_read("reg read disabled", 48'hC000_0000_0000, 1, w);
        w = '{16'h1234, 16'h0000, 16'h0000, 16'h0000};
        do_write("reg write dropped", 48'h6000_0100_0000, 1, 1'b0, w, 4'b0000);
        w = '{16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
        do_read("mem after reg write", 48'hA000_0000_0000, 1, w);
`endif

        // Abort after two CA words; third word arrives with csn already high
        bus.csn   = 1'b0;
        bus.ck_en = 1'b0;
        tick();
        bus.ck_en = 1'b1;
        bus.dq_in = 16'h2000;
        tick();
        bus.dq_in = 16'h0000;
        tick();
        bus.csn   = 1'b1;
        bus.dq_in = 16'h0004;
        tick();
        bus.ck_en = 1'b0;
        check_bit("abort busy", bus.busy, 1'b0);
        check_bit("abort rwds_oe", bus.rwds_oe, 1'b0);
        check_bit("abort dq_oe", bus.dq_oe, 1'b0);
        $display("abort after 2 CA words");
        tick();
        do_read("read after abort", vecs[1].ca, vecs[1].n, vecs[1].d);

        // Asynchronous reset in the middle of a read burst
        start_ca(48'hA000_0000_0004);
        bus.ck_en = 1'b1;
        repeat (LAT + 1) tick();
        check_bit("pre-reset dq_oe", bus.dq_oe, 1'b1);
        rst = 1'b0;
        #1;
        check("mid-burst reset dq_out", bus.dq_out, 16'h0000);
        check_bit("mid-burst reset dq_oe", bus.dq_oe, 1'b0);
        check_bit("mid-burst reset rwds_out", bus.rwds_out, 1'b0);
        check_bit("mid-burst reset rwds_oe", bus.rwds_oe, 1'b0);
        check_bit("mid-burst reset busy", bus.busy, 1'b0);
        bus.csn   = 1'b1;
        bus.ck_en = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_bit("busy after mid-burst reset", bus.busy, 1'b0);
        $display("reset mid-burst");
`ifdef HYPERRAM_RESP_REGSPACE_EN
        w = '{16'h8F1F, 16'h0000, 16'h0000, 16'h0000};
        do_read("CR0 after reset", 48'hC000_0100_0000, 1, w);
`endif
        w = '{16'h1111, 16'h0000, 16'h0000, 16'h0000};
        do_read("memory kept over reset", 48'hA000_0000_0004, 1, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
